// File: rtl/memory_router.sv
// Routes the single memory port to NSLV address windows, one transaction in flight, with bus error on miss/timeout.
// Optional ROUTER_STATS_EN adds saturating completed/error transaction counters.
module memory_router #(
  parameter int unsigned            NSLV      = 3,
  parameter logic [NSLV*32-1:0]     BASE_ADDR = {32'h00000000, 32'h10000000, 32'h02000000},
  parameter logic [NSLV*32-1:0]     TOP_ADDR  = {32'h00100000, 32'h10001000, 32'h0200C000},
  parameter int unsigned            TIMEOUT   = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 memory_valid,
  input  logic                 memory_instr,
  input  logic [31:0]          memory_addr,
  input  logic [31:0]          memory_wdata,
  input  logic [3:0]           memory_wstrb,
  output logic [31:0]          memory_rdata,
  output logic                 memory_ready,
  output logic                 memory_error,
  output logic [NSLV-1:0]      slv_valid,
  output logic                 slv_instr,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  output logic [3:0]           slv_wstrb,
  input  logic [NSLV*32-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ready,
  output logic [31:0]          stat_count,
  output logic [31:0]          stat_error
);

  localparam int unsigned SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [15:0]       timer_q, timer_d;

  logic              hit;
  logic [SEL_W-1:0]  hit_idx;

  // Scan upward and keep the first match so overlapping windows resolve to the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (!hit && memory_addr >= BASE_ADDR[32*i +: 32] && memory_addr < TOP_ADDR[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign slv_addr  = memory_addr - BASE_ADDR[32*int'(hit_idx) +: 32];
  assign slv_instr = memory_instr;
  assign slv_wdata = memory_wdata;
  assign slv_wstrb = memory_wstrb;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    slv_valid    = '0;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (memory_valid) begin
          if (hit) begin
            slv_valid[hit_idx] = 1'b1;
            sel_d              = hit_idx;
            timer_d            = 16'h0;
            state_d            = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        timer_d = timer_q + 16'h1;
        if (slv_ready[sel_q]) begin
          memory_ready = 1'b1;
          memory_rdata = slv_rdata[32*int'(sel_q) +: 32];
          state_d      = IDLE;
        end else if (timer_q == 16'(TIMEOUT)) begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
          state_d      = IDLE;
        end
      end
      ERR: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so the old state is still visible this cycle; mask it.
    if (reset) begin
      slv_valid    = '0;
      memory_ready = 1'b0;
      memory_error = 1'b0;
      memory_rdata = 32'h0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      timer_q <= 16'h0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
    end
  end

`ifdef ROUTER_STATS_EN
  logic [31:0] stat_count_q, stat_count_d;
  logic [31:0] stat_error_q, stat_error_d;

  always_comb begin
    stat_count_d = stat_count_q;
    stat_error_d = stat_error_q;
    if (memory_ready && stat_count_q != 32'hFFFFFFFF) stat_count_d = stat_count_q + 32'h1;
    if (memory_ready && memory_error && stat_error_q != 32'hFFFFFFFF) stat_error_d = stat_error_q + 32'h1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_count_q <= 32'h0;
      stat_error_q <= 32'h0;
    end else begin
      stat_count_q <= stat_count_d;
      stat_error_q <= stat_error_d;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_error = stat_error_q;
`else
  assign stat_count = 32'h0;
  assign stat_error = 32'h0;
`endif

endmodule

// File: tb/tb_memory_router.sv
// Scoreboard bench for memory_router: expected responses queued at request time, compared on memory_ready.
module tb_memory_router;

  logic        clock = 1'b0;
  logic        reset;
  logic        memory_valid, memory_instr;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0]  memory_wstrb;
  logic        memory_ready, memory_error;
  logic [2:0]  slv_valid, slv_ready;
  logic        slv_instr;
  logic [31:0] slv_addr, slv_wdata;
  logic [3:0]  slv_wstrb;
  logic [95:0] slv_rdata;
  logic [31:0] stat_count, stat_error;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_err = 0;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];

  memory_router #(.NSLV(3), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .memory_error(memory_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .stat_count(stat_count), .stat_error(stat_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
    exp_cnt++;
    if (err) exp_err++;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [2:0] exp_vld, input logic [31:0] exp_addr);
    memory_valid = 1'b1;
    memory_addr  = addr;
    memory_wdata = wd;
    memory_wstrb = ws;
    @(negedge clock);
    chk("req_vld", 32'(slv_valid), 32'(exp_vld));
    if (exp_vld != 3'b000) begin
      chk("req_addr", slv_addr, exp_addr);
      chk("req_wdata", slv_wdata, wd);
      chk("req_wstrb", 32'(slv_wstrb), 32'(ws));
    end
    tick();
    memory_valid = 1'b0;
  endtask

  task automatic resp(input int idx, input logic [31:0] data, input int lat);
    repeat (lat - 1) tick();
    slv_ready[idx]          = 1'b1;
    slv_rdata[32*idx +: 32] = data;
    tick();
    slv_ready = 3'b000;
  endtask

  always @(negedge clock) begin
    if (!reset && memory_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ready", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", memory_rdata, e.rdata);
        chk("sb_error", 32'(memory_error), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memory_valid = 1'b0; memory_instr = 1'b0;
    memory_addr = '0; memory_wdata = '0; memory_wstrb = '0;
    slv_rdata = '0; slv_ready = '0;
    tick(); tick();
    @(negedge clock);
    chk("rst_vld", 32'(slv_valid), 32'h0);
    chk("rst_ready", 32'(memory_ready), 32'h0);
    chk("rst_error", 32'(memory_error), 32'h0);
    chk("rst_rdata", memory_rdata, 32'h0);
    chk("rst_stat_count", stat_count, 32'h0);
    chk("rst_stat_error", stat_error, 32'h0);
    tick();
    reset = 1'b0;

    // Reset while BUSY: slave ready during reset and right after must not surface.
    do_req(32'h02000010, 32'h0, 4'h0, 3'b001, 32'h10);
    reset = 1'b1;
    slv_ready[0] = 1'b1;
    slv_rdata[31:0] = 32'hCAFE0000;
    @(negedge clock);
    chk("midrst_ready", 32'(memory_ready), 32'h0);
    chk("midrst_rdata", memory_rdata, 32'h0);
    chk("midrst_error", 32'(memory_error), 32'h0);
    chk("midrst_vld", 32'(slv_valid), 32'h0);
    exp_cnt = 0;
    exp_err = 0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_drop", 32'(memory_ready), 32'h0);
    tick();
    slv_ready = 3'b000;
    push(32'h11112222, 1'b0);
    do_req(32'h02000020, 32'h0, 4'h0, 3'b001, 32'h20);
    resp(0, 32'h11112222, 1);

    // Read to slot 0, slave latency 3.
    push(32'hDEADBEEF, 1'b0);
    memory_instr = 1'b1;
    do_req(32'h02000008, 32'h0, 4'h0, 3'b001, 32'h8);
    @(negedge clock);
    chk("busy_no_fwd", 32'(slv_valid), 32'h0);
    chk("instr_bcast", 32'(slv_instr), 32'h1);
    memory_instr = 1'b0;
    resp(0, 32'hDEADBEEF, 3);

    // Write to slot 1 with spurious slot-2 ready and an illegal request while BUSY.
    push(32'h12345678, 1'b0);
    do_req(32'h10000000, 32'h41, 4'hF, 3'b010, 32'h0);
    slv_ready[2] = 1'b1;
    slv_rdata[95:64] = 32'h00000BAD;
    memory_valid = 1'b1;
    memory_addr  = 32'h80000000;
    @(negedge clock);
    chk("spurious_ready", 32'(memory_ready), 32'h0);
    chk("busy_req_ignored", 32'(slv_valid), 32'h0);
    tick();
    memory_valid = 1'b0;
    slv_ready = 3'b000;
    resp(1, 32'h12345678, 1);

    // Unmapped address: one-cycle error response.
    push(32'h0, 1'b1);
    do_req(32'h80000000, 32'h0, 4'h0, 3'b000, 32'h0);
    @(negedge clock);
    chk("miss_ready", 32'(memory_ready), 32'h1);
    tick();
    @(negedge clock);
    chk("miss_one_cycle", 32'(memory_ready), 32'h0);
    tick();

    // Timeout on slot 2, then a late ready that must be dropped.
    push(32'h0, 1'b1);
    do_req(32'h00000100, 32'h0, 4'h0, 3'b100, 32'h100);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("to_wait", 32'(memory_ready), 32'h0);
      tick();
    end
    @(negedge clock);
    chk("to_fire", 32'(memory_ready & memory_error), 32'h1);
    tick();
    slv_ready[2] = 1'b1;
    slv_rdata[95:64] = 32'h00000055;
    @(negedge clock);
    chk("late_drop", 32'(memory_ready), 32'h0);
    tick();
    slv_ready = 3'b000;
    push(32'h00000077, 1'b0);
    do_req(32'h10000010, 32'h0, 4'h0, 3'b010, 32'h10);
    resp(1, 32'h00000077, 2);

    // Randomised hits to slot 2 (base 0: address passes unchanged).
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, d;
      int lat;
      a   = 32'h1000 * i + 32'h4;
      d   = $urandom;
      lat = $urandom_range(1, 4);
      push(d, 1'b0);
      do_req(a, 32'h0, 4'h0, 3'b100, a);
      resp(2, d, lat);
    end

    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);
`ifdef ROUTER_STATS_EN
    chk("stat_count", stat_count, 32'(exp_cnt));
    chk("stat_error", stat_error, 32'(exp_err));
`else
    chk("stat_count_off", stat_count, 32'h0);
    chk("stat_error_off", stat_error, 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
